// File: rtl/dqn_fp32_pkg.sv
// Shared definitions for the DQN FP32 datapath: word width, operand count
// and the arbiter FSM state encoding.
package dqn_fp32_pkg;

  localparam int FP32_WIDTH      = 32;
  localparam int ADDER3_OPERANDS = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    ISSUE0  = 3'd2,
    ISSUE1  = 3'd3,
    ISSUE2  = 3'd4
  } arbState_e;

endpackage

// File: rtl/adder3_arbiter_floating_point32_tag_fifo.sv
// Small synchronous FIFO holding the requester ID of every job in flight
// through the adder; pointers carry one extra wrap bit to tell full from empty.
module tag_fifo_sync #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  assign empty   = (wrPtr_q == rdPtr_q);
  assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/adder3_arbiter_floating_point32.sv
// Round-robin arbiter sharing one 3-input FP32 adder among NUM_REQ requesters:
// gathers A, B, bias from the winner, issues them as one burst, routes results back.
module adder3_arbiter_floating_point32
  import dqn_fp32_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [FP32_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          add_valid,
  output logic [FP32_WIDTH-1:0]         add_data,
  input  logic                          add_o_valid,
  input  logic [FP32_WIDTH-1:0]         add_o_data,
  output logic [NUM_REQ-1:0]            res_valid,
  output logic [FP32_WIDTH-1:0]         res_data,
  output logic [ID_WIDTH-1:0]           res_id,
  output logic                          busy,
  output logic                          err
);

  arbState_e               state_q, state_d;
  logic [ID_WIDTH-1:0]     grantId_q, grantId_d;
  logic [ID_WIDTH-1:0]     rrPtr_q, rrPtr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [FP32_WIDTH-1:0]   wordBuf_q [ADDER3_OPERANDS];

  logic [NUM_REQ-1:0]      reqReady_q, reqReady_d;
  logic                    addValid_q, addValid_d;
  logic [FP32_WIDTH-1:0]   addData_q, addData_d;
  logic [NUM_REQ-1:0]      resValid_q;
  logic [FP32_WIDTH-1:0]   resData_q;
  logic [ID_WIDTH-1:0]     resId_q;
  logic                    err_q;

  logic                    accept;
  logic [FP32_WIDTH-1:0]   grantWord;
  logic                    tagFull;
  logic                    tagEmpty;
  logic [ID_WIDTH-1:0]     tagHead;
  logic                    tagPush;

  // First valid requester at or above ptr, otherwise the first one below it.
  function automatic logic [ID_WIDTH-1:0] rrPick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH-1:0] pick;
    logic                found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (i >= int'(ptr))) begin
        pick  = ID_WIDTH'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i]) begin
        pick  = ID_WIDTH'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [ID_WIDTH-1:0] nextId(input logic [ID_WIDTH-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  assign accept    = (state_q == COLLECT) && |(req_valid & reqReady_q);
  assign grantWord = req_data[FP32_WIDTH*int'(grantId_q) +: FP32_WIDTH];
  assign tagPush   = (state_q == ISSUE2);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      grantId_q <= '0;
      rrPtr_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      rrPtr_q   <= rrPtr_d;
      cnt_q     <= cnt_d;
    end
  end

  // The full check gates the grant, so an accepted job always has a tag slot.
  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
    rrPtr_d   = rrPtr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid && !tagFull) begin
          grantId_d = rrPick(req_valid, rrPtr_q);
          rrPtr_d   = nextId(grantId_d);
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (cnt_q == 2'(ADDER3_OPERANDS - 1)) begin
            cnt_d   = '0;
            state_d = ISSUE0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ISSUE0:  state_d = ISSUE1;
      ISSUE1:  state_d = ISSUE2;
      ISSUE2:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reqReady_d = '0;
    addValid_d = 1'b0;
    addData_d  = '0;
    unique case (state_d)
      COLLECT: reqReady_d = NUM_REQ'(1) << grantId_d;
      ISSUE0: begin
        addValid_d = 1'b1;
        addData_d  = wordBuf_q[0];
      end
      ISSUE1: begin
        addValid_d = 1'b1;
        addData_d  = wordBuf_q[1];
      end
      ISSUE2: begin
        addValid_d = 1'b1;
        addData_d  = wordBuf_q[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wordBuf_q[0] <= '0;
      wordBuf_q[1] <= '0;
      wordBuf_q[2] <= '0;
    end else if (accept) begin
      case (cnt_q)
        2'd0:    wordBuf_q[0] <= grantWord;
        2'd1:    wordBuf_q[1] <= grantWord;
        default: wordBuf_q[2] <= grantWord;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      reqReady_q <= '0;
      addValid_q <= 1'b0;
      addData_q  <= '0;
    end else begin
      reqReady_q <= reqReady_d;
      addValid_q <= addValid_d;
      addData_q  <= addData_d;
    end
  end

  // A result with no outstanding tag is dropped and latched as an error.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      resValid_q <= '0;
      resData_q  <= '0;
      resId_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      resValid_q <= '0;
      if (add_o_valid && tagEmpty) begin
        err_q <= 1'b1;
      end
      if (add_o_valid && !tagEmpty) begin
        resValid_q <= NUM_REQ'(1) << tagHead;
        resId_q    <= tagHead;
        resData_q  <= add_o_data;
      end
    end
  end

  tag_fifo_sync #(
    .WIDTH (ID_WIDTH),
    .DEPTH (TAG_DEPTH)
  ) u_tagFifo (
    .clk     (clk),
    .rst     (rst_n),
    .push    (tagPush),
    .wdata_i (grantId_q),
    .pop     (add_o_valid),
    .rdata_o (tagHead),
    .full    (tagFull),
    .empty   (tagEmpty)
  );

  assign req_ready = reqReady_q;
  assign add_valid = addValid_q;
  assign add_data  = addData_q;
  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_id    = resId_q;
  assign busy      = (state_q != IDLE) || !tagEmpty;
  assign err       = err_q;

endmodule

// File: tb/tb_adder3_arbiter_floating_point32.sv
// Directed bench for the adder3 arbiter: single job, round robin, COLLECT gaps,
// full tag FIFO, reset mid-job and spurious results, all against hand values.
module tb_adder3_arbiter_floating_point32;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         add_valid;
  logic [31:0]  add_data;
  logic         add_o_valid;
  logic [31:0]  add_o_data;
  logic [3:0]   res_valid;
  logic [31:0]  res_data;
  logic [1:0]   res_id;
  logic         busy;
  logic         err;

  int total;
  int bad;

  adder3_arbiter_floating_point32 #(
    .NUM_REQ   (4),
    .ID_WIDTH  (2),
    .TAG_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .add_valid   (add_valid),
    .add_data    (add_data),
    .add_o_valid (add_o_valid),
    .add_o_data  (add_o_data),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_id      (res_id),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [31:0] word);
    req_data[32*r +: 32] = word;
  endtask

  // Drives one 3-word job from requester r (only r valid), then returns sum.
  task automatic runJob(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] sum);
    logic [3:0] oh;
    oh = 4'b0001 << r;
    req_valid = oh;
    applyStimulus(r, a);
    @(negedge clk);
    checkOutput("job_ready", {28'd0, req_ready}, {28'd0, oh});
    @(negedge clk);
    applyStimulus(r, b);
    @(negedge clk);
    applyStimulus(r, c);
    @(negedge clk);
    req_valid = 4'b0000;
    checkOutput("job_issue0_valid", {31'd0, add_valid}, 32'd1);
    checkOutput("job_issue0_data", add_data, a);
    checkOutput("job_ready_off", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("job_issue1_data", add_data, b);
    @(negedge clk);
    checkOutput("job_issue2_data", add_data, c);
    @(negedge clk);
    checkOutput("job_issue_end", {31'd0, add_valid}, 32'd0);
    checkOutput("job_busy_inflight", {31'd0, busy}, 32'd1);
    add_o_valid = 1'b1;
    add_o_data  = sum;
    @(negedge clk);
    add_o_valid = 1'b0;
    checkOutput("job_res_valid", {28'd0, res_valid}, {28'd0, oh});
    checkOutput("job_res_id", {30'd0, res_id}, r);
    checkOutput("job_res_data", res_data, sum);
    @(negedge clk);
    checkOutput("job_res_strobe_end", {28'd0, res_valid}, 32'd0);
    checkOutput("job_busy_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b1;
    req_valid   = 4'b0000;
    req_data    = '0;
    add_o_valid = 1'b0;
    add_o_data  = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("rst_add_valid", {31'd0, add_valid}, 32'd0);
    checkOutput("rst_add_data", add_data, 32'd0);
    checkOutput("rst_res_valid", {28'd0, res_valid}, 32'd0);
    checkOutput("rst_res_data", res_data, 32'd0);
    checkOutput("rst_res_id", {30'd0, res_id}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);

    // Round robin: all requesters valid, grant order 0,1,2,3,0
    for (int r = 0; r < 4; r++) applyStimulus(r, 32'hA000_0000 | r);
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        add_o_valid = 1'b1;
        add_o_data  = 32'hC000_0000 | ((j - 1) % 4);
      end
      @(negedge clk);
      add_o_valid = 1'b0;
      if (j > 0) begin
        checkOutput("rr_res_valid", {28'd0, res_valid}, 32'd1 << ((j - 1) % 4));
        checkOutput("rr_res_id", {30'd0, res_id}, (j - 1) % 4);
        checkOutput("rr_res_data", res_data, 32'hC000_0000 | ((j - 1) % 4));
      end
      checkOutput("rr_grant", {28'd0, req_ready}, 32'd1 << (j % 4));
      repeat (3) @(negedge clk);
      checkOutput("rr_issue_data", add_data, 32'hA000_0000 | (j % 4));
      repeat (3) @(negedge clk);
    end
    req_valid   = 4'b0000;
    add_o_valid = 1'b1;
    add_o_data  = 32'hC000_0000;
    @(negedge clk);
    add_o_valid = 1'b0;
    checkOutput("rr_last_res_id", {30'd0, res_id}, 32'd0);
    checkOutput("rr_last_res_valid", {28'd0, res_valid}, 32'd1);

    // Single job: 1.0 + 2.0 + 0.5 = 3.5 from requester 2
    runJob(2, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4060_0000);

    // Gaps in COLLECT: requester 1, valid pattern 1,0,0,1,0,1
    req_valid = 4'b0010;
    applyStimulus(1, 32'h1111_0001);
    @(negedge clk);
    checkOutput("gap_grant", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    applyStimulus(1, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("gap_hold_ready", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = 4'b0010;
    applyStimulus(1, 32'h1111_0002);
    @(negedge clk);
    req_valid = 4'b0000;
    applyStimulus(1, 32'hDEAD_BEEF);
    checkOutput("gap_no_issue", {31'd0, add_valid}, 32'd0);
    @(negedge clk);
    req_valid = 4'b0010;
    applyStimulus(1, 32'h1111_0003);
    @(negedge clk);
    req_valid = 4'b0000;
    checkOutput("gap_issue0", add_data, 32'h1111_0001);
    checkOutput("gap_issue0_valid", {31'd0, add_valid}, 32'd1);
    @(negedge clk);
    checkOutput("gap_issue1", add_data, 32'h1111_0002);
    checkOutput("gap_issue1_valid", {31'd0, add_valid}, 32'd1);
    @(negedge clk);
    checkOutput("gap_issue2", add_data, 32'h1111_0003);
    checkOutput("gap_issue2_valid", {31'd0, add_valid}, 32'd1);
    @(negedge clk);
    add_o_valid = 1'b1;
    add_o_data  = 32'h4040_0000;
    @(negedge clk);
    add_o_valid = 1'b0;
    checkOutput("gap_res_id", {30'd0, res_id}, 32'd1);

    // FIFO full: depth 2, results held back ~40 cycles, requester 3 always valid
    req_valid = 4'b1000;
    applyStimulus(3, 32'h3F80_0000);
    for (int n = 1; n <= 56; n++) begin
      @(negedge clk);
      add_o_valid = 1'b0;
      if (n >= 15 && n <= 47) begin
        checkOutput("full_blocked_ready", {28'd0, req_ready}, 32'd0);
        checkOutput("full_busy", {31'd0, busy}, 32'd1);
      end
      if (n == 47 || n == 54 || n == 55) begin
        checkOutput("full_res_valid", {28'd0, res_valid}, 32'h8);
        checkOutput("full_res_id", {30'd0, res_id}, 32'd3);
        checkOutput("full_res_data", res_data, 32'h1111_1111 * ((n == 47) ? 1 : n - 52));
      end
      if (n == 46 || n == 53 || n == 54) begin
        add_o_valid = 1'b1;
        add_o_data  = 32'h1111_1111 * ((n == 46) ? 1 : n - 51);
      end
      if (n == 48) checkOutput("full_regrant", {28'd0, req_ready}, 32'h8);
      if (n == 51) req_valid = 4'b0000;
      if (n == 56) checkOutput("full_drained_busy", {31'd0, busy}, 32'd0);
    end

    // Reset mid-COLLECT after two words from requester 1
    req_valid = 4'b0010;
    applyStimulus(1, 32'h0000_0011);
    @(negedge clk);
    checkOutput("mid_grant", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    applyStimulus(1, 32'h0000_0022);
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    #1;
    checkOutput("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("mid_rst_add_valid", {31'd0, add_valid}, 32'd0);
    checkOutput("mid_rst_add_data", add_data, 32'd0);
    checkOutput("mid_rst_res_valid", {28'd0, res_valid}, 32'd0);
    checkOutput("mid_rst_res_data", res_data, 32'd0);
    checkOutput("mid_rst_res_id", {30'd0, res_id}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int r = 0; r < 4; r++) applyStimulus(r, 32'hB000_0000 | r);
    applyStimulus(0, 32'h4120_0000);
    req_valid = 4'b1111;
    @(negedge clk);
    checkOutput("post_rst_grant0", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    applyStimulus(0, 32'h41A0_0000);
    @(negedge clk);
    applyStimulus(0, 32'h3F80_0000);
    @(negedge clk);
    req_valid = 4'b0000;
    checkOutput("post_rst_issue0", add_data, 32'h4120_0000);
    @(negedge clk);
    checkOutput("post_rst_issue1", add_data, 32'h41A0_0000);
    @(negedge clk);
    checkOutput("post_rst_issue2", add_data, 32'h3F80_0000);
    @(negedge clk);
    add_o_valid = 1'b1;
    add_o_data  = 32'h41F8_0000;
    @(negedge clk);
    add_o_valid = 1'b0;
    checkOutput("post_rst_res_id", {30'd0, res_id}, 32'd0);
    checkOutput("post_rst_res_data", res_data, 32'h41F8_0000);

    // Spurious result with empty tag FIFO
    @(negedge clk);
    add_o_valid = 1'b1;
    add_o_data  = 32'h0BAD_0BAD;
    @(negedge clk);
    add_o_valid = 1'b0;
    checkOutput("spur_err", {31'd0, err}, 32'd1);
    checkOutput("spur_no_res", {28'd0, res_valid}, 32'd0);
    checkOutput("spur_busy", {31'd0, busy}, 32'd0);
    runJob(2, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h40A0_0000);
    checkOutput("spur_err_sticky", {31'd0, err}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder3_arbiter_floating_point32.md
# adder3_arbiter_floating_point32

Round-robin scheduler that shares one 3-input FP32 adder pipeline (A + B + bias, two chained FP32 adders) among `NUM_REQ` requesters, typically the neuron units of one DQN layer. It collects each requester's three operand words through a valid/ready handshake and issues them to the adder as one gap-free 3-cycle burst. It tags each job with its requester ID and routes every adder result back to the requester that issued it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters.
- `ID_WIDTH`, 2: requester ID width; must satisfy 2^`ID_WIDTH` ≥ `NUM_REQ`.
- `TAG_DEPTH`, 8: maximum in-flight jobs; power of two.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous reset, active-high.
- `req_valid`  in  `NUM_REQ`: requester r offers an operand word.
- `req_data`  in  32·`NUM_REQ`: flattened FP32 words; requester r occupies bits [32r+31:32r].
- `req_ready`  out  `NUM_REQ`: one-hot; the word from requester r is accepted when `req_valid[r]` & `req_ready[r]`.
- `add_valid`  out  1: valid to the adder pipeline.
- `add_data`  out  32: operand word to the adder pipeline.
- `add_o_valid`  in  1: adder result valid.
- `add_o_data`  in  32: adder result.
- `res_valid`  out  `NUM_REQ`: one-hot, 1-cycle result strobe.
- `res_data`  out  32: result value.
- `res_id`  out  `ID_WIDTH`: ID of the requester that owns the result.
- `busy`  out  1: state ≠ IDLE, or tag FIFO not empty.
- `err`  out  1: sticky flag; set on a result that arrives with no outstanding tag.

## Operation
- FSM states: IDLE, COLLECT, ISSUE0, ISSUE1, ISSUE2.
- **IDLE.** If any `req_valid` is high and the tag FIFO is not full:
  - search upward from `rr_ptr`, wrapping at `NUM_REQ`; the first requester with `req_valid` high wins;
  - register `grant_id`;
  - set `rr_ptr` to `grant_id`+1 mod `NUM_REQ`;
  - go to COLLECT.
- **COLLECT.** `req_ready[grant_id]` is high and every other ready bit is low.
  - Each handshake stores the word into `buf[cnt]` and increments a 2-bit `cnt`.
  - Gaps in `req_valid` are allowed; the FSM waits.
  - The 3rd handshake (`cnt`=2) moves the FSM to ISSUE0 and clears `cnt`.
- **Word order.** Word 0 = A, word 1 = B, word 2 = bias.
- **ISSUE0/1/2.** `add_valid`=1 with `add_data` = `buf[0]`, `buf[1]`, `buf[2]` on three consecutive cycles.
  - The burst can never be stalled; the adder latches the bias without checking valid.
  - ISSUE2 pushes `grant_id` into the tag FIFO, then returns to IDLE.
- **Result path.**
  - On `add_o_valid`, pop the tag FIFO.
  - On the next cycle drive `res_valid[tag]`=1, `res_id`=tag and `res_data`=`add_o_data` (registered).
  - There is no backpressure; requesters must accept the result.
- **Spurious result.** `add_o_valid` with an empty FIFO sets `err`, produces no `res_valid`, and leaves the FIFO unchanged.
- **Simultaneous push and pop.** Push (ISSUE2) and pop in the same cycle are both legal, and the FIFO count stays unchanged.
- **Full FIFO.** A full FIFO blocks a new grant in IDLE. It never blocks a job that has already been granted, because the full check happens before the grant.
- **Reset while asserted.** All state is cleared:
  - FSM = IDLE, `cnt`=0, `rr_ptr`=0, FIFO empty, `err`=0;
  - buffered words and in-flight tags are discarded.
  - The downstream adder shares this reset.
- **Reset values.** All outputs are 0: `req_ready`, `add_valid`, `add_data`, `res_valid`, `res_data`, `res_id`, `busy`, `err`.

## Timing
- Requester visible in IDLE at cycle t → `req_ready` high at t+1.
- Third word accepted at cycle u → ISSUE0 (`add_valid` high) at u+1, ISSUE2 at u+3, IDLE at u+4.
- Minimum job period: 7 cycles (1 IDLE + 3 COLLECT + 3 ISSUE).
- `add_o_valid` at cycle v → `res_valid` at v+1.
- End-to-end latency = 4 + adder latency + 1 cycles, measured from the third word accept to `res_valid`.
- `req_ready` is a registered output, driven from the FSM state and `grant_id` only.
- `add_valid` and `add_data` are registered outputs.

## Structure
- Shared package `dqn_fp32_pkg` holds:
  - `FP32_WIDTH`=32;
  - the FSM state encoding: IDLE=0, COLLECT=1, ISSUE0=2, ISSUE1=3, ISSUE2=4;
  - the constant `ADDER3_OPERANDS`=3.
- One sub-module, `tag_fifo_sync`:
  - parameters `WIDTH`=`ID_WIDTH` and `DEPTH`=`TAG_DEPTH`;
  - ports: push, pop, full, empty;
  - an extra count bit in the pointers to distinguish full from empty.
- The round-robin search is a combinational function inside the top module.

## Test plan
- **Single job.** Requester 2 sends 1.0, 2.0, 0.5 on back-to-back cycles → `add_data` = 0x3F800000, 0x40000000, 0x3F000000 on three consecutive cycles; after the adder result 0x40600000 (3.5): `res_valid`=4'b0100, `res_id`=2.
- **Round robin.** All 4 requesters hold `req_valid` high → grant order 0, 1, 2, 3, 0; each result is returned with the matching `res_id`.
- **Gaps in COLLECT.** `req_valid` toggles 1, 0, 0, 1, 0, 1 → exactly 3 words accepted in order; the ISSUE burst stays gap-free.
- **FIFO full.** `TAG_DEPTH`=2 with a stub adder of latency 40 → the third grant is blocked (`req_ready` stays 0) until the first result pops; `busy` stays 1 throughout.
- **Reset mid-COLLECT.** Assert `rst_n` after 2 accepted words → all outputs read 0; afterwards a fresh 3-word job issues correctly and `rr_ptr` restarts at 0.
- **Spurious result.** `add_o_valid` pulsed with an empty FIFO → `err`=1 and stays sticky, with no `res_valid`; a subsequent normal job still completes.
